updslow_llr_fifo_packer: RTL and testbench

- Write-side counterpart of the slow PHY-to-LLR serializer.
- Accepts per-cycle RE-pair IQ beats and 16-bit noise samples from the upstream PHY, and packs them into 128-bit words.
- Writes the packed words into the IQ FIFO and the noise FIFO that the serializer drains.
- Tracks one user allocation per start pulse and flushes partial words at the end of the user.

---
 rtl/updslow_llr_fifo_packer.sv | 208 ++++++++++++++++++++
 tb/tb_updslow_llr_fifo_packer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/updslow_llr_fifo_packer.sv
// Packs RE-pair IQ beats and 16-bit noise samples into 128-bit words for the IQ and
// noise FIFOs drained by the slow LLR serializer; one user allocation per start pulse.
module updslow_llr_fifo_packer #(
    parameter int NOISE_PER_WORD = 8,
    parameter int RE_CNT_W       = 16
) (
    input  logic                i_core_clk,
    input  logic                i_rx_rstn,
    input  logic                i_rx_fsm_rstn,
    input  logic                i_user_start,
    input  logic [RE_CNT_W-1:0] i_user_re_num,
    input  logic                i_data_strobe,
    input  logic [15:0]         i_re0_data_i,
    input  logic [15:0]         i_re0_data_q,
    input  logic [15:0]         i_re1_data_i,
    input  logic [15:0]         i_re1_data_q,
    input  logic                i_noise_strobe,
    input  logic [15:0]         i_noise_data,
    input  logic                i_iq_fifo_full,
    input  logic                i_noise_fifo_full,
    output logic                o_iq_fifo_wr_en,
    output logic [127:0]        o_iq_fifo_wr_data,
    output logic                o_noise_fifo_wr_en,
    output logic [127:0]        o_noise_fifo_wr_data,
    output logic                o_busy,
    output logic                o_user_done,
    output logic                o_overflow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PACK  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int IDX_W = $clog2(NOISE_PER_WORD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NOISE_PER_WORD - 1);
    localparam logic [RE_CNT_W-1:0] RE_NUM_SAT = {{(RE_CNT_W-1){1'b1}}, 1'b0};

    // Either reset line returns the whole block to IDLE immediately.
    logic rst_n;
    assign rst_n = i_rx_rstn & i_rx_fsm_rstn;

    logic [1:0]          state_q, state_d;
    logic [RE_CNT_W-1:0] re_num_q, re_num_d;
    logic [RE_CNT_W-1:0] re_cnt_q, re_cnt_d;
    logic                iq_half_q, iq_half_d;
    logic [63:0]         iq_word_q, iq_word_d;
    logic [IDX_W-1:0]    noise_idx_q, noise_idx_d;
    logic [127:0]        noise_word_q, noise_word_d;
    logic                iq_wr_en_q, iq_wr_en_d;
    logic [127:0]        iq_wr_data_q, iq_wr_data_d;
    logic                noise_wr_en_q, noise_wr_en_d;
    logic [127:0]        noise_wr_data_q, noise_wr_data_d;
    logic                overflow_q, overflow_d;
    logic                done_q, done_d;

    logic [RE_CNT_W:0]   re_num_rnd;
    logic [RE_CNT_W-1:0] re_num_eff;
    logic [RE_CNT_W-1:0] re_cnt_inc;
    logic [63:0]         iq_beat;
    logic [127:0]        noise_fill;

    // Odd RE counts round up to even; the all-ones count would carry out and saturates instead.
    assign re_num_rnd = {1'b0, i_user_re_num} + {{RE_CNT_W{1'b0}}, i_user_re_num[0]};
    assign re_num_eff = re_num_rnd[RE_CNT_W] ? RE_NUM_SAT : re_num_rnd[RE_CNT_W-1:0];
    assign re_cnt_inc = re_cnt_q + RE_CNT_W'(2);
    assign iq_beat    = {i_re1_data_q, i_re1_data_i, i_re0_data_q, i_re0_data_i};

    always_comb begin
        state_d         = state_q;
        re_num_d        = re_num_q;
        re_cnt_d        = re_cnt_q;
        iq_half_d       = iq_half_q;
        iq_word_d       = iq_word_q;
        noise_idx_d     = noise_idx_q;
        noise_word_d    = noise_word_q;
        iq_wr_en_d      = 1'b0;
        iq_wr_data_d    = iq_wr_data_q;
        noise_wr_en_d   = 1'b0;
        noise_wr_data_d = noise_wr_data_q;
        overflow_d      = overflow_q;
        noise_fill      = noise_word_q;
        noise_fill[noise_idx_q*16 +: 16] = i_noise_data;

        // A start in any state (re)opens a user and discards whatever was partially packed.
        if (i_user_start) begin
            re_num_d     = re_num_eff;
            re_cnt_d     = '0;
            iq_half_d    = 1'b0;
            iq_word_d    = '0;
            noise_idx_d  = '0;
            noise_word_d = '0;
            overflow_d   = 1'b0;
            state_d      = (re_num_eff == '0) ? ST_DONE : ST_PACK;
        end else begin
            case (state_q)
                ST_PACK: begin
                    if (i_data_strobe) begin
                        re_cnt_d = re_cnt_inc;
                        if (iq_half_q) begin
                            iq_half_d = 1'b0;
                            iq_word_d = '0;
                            if (i_iq_fifo_full) begin
                                overflow_d = 1'b1;
                            end else begin
                                iq_wr_en_d   = 1'b1;
                                iq_wr_data_d = {iq_beat, iq_word_q};
                            end
                        end else begin
                            iq_half_d = 1'b1;
                            iq_word_d = iq_beat;
                        end
                        if (re_cnt_inc >= re_num_q) begin
                            state_d = ST_FLUSH;
                        end
                    end
                    if (i_noise_strobe) begin
                        if (noise_idx_q == IDX_LAST) begin
                            noise_idx_d  = '0;
                            noise_word_d = '0;
                            if (i_noise_fifo_full) begin
                                overflow_d = 1'b1;
                            end else begin
                                noise_wr_en_d   = 1'b1;
                                noise_wr_data_d = noise_fill;
                            end
                        end else begin
                            noise_idx_d  = noise_idx_q + IDX_W'(1);
                            noise_word_d = noise_fill;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Upper IQ half and unused noise lanes are already zero in the packing registers.
                    if (iq_half_q) begin
                        if (i_iq_fifo_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            iq_wr_en_d   = 1'b1;
                            iq_wr_data_d = {64'd0, iq_word_q};
                        end
                    end
                    if (noise_idx_q != '0) begin
                        if (i_noise_fifo_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            noise_wr_en_d   = 1'b1;
                            noise_wr_data_d = noise_word_q;
                        end
                    end
                    iq_half_d    = 1'b0;
                    iq_word_d    = '0;
                    noise_idx_d  = '0;
                    noise_word_d = '0;
                    state_d      = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            re_num_q        <= '0;
            re_cnt_q        <= '0;
            iq_half_q       <= 1'b0;
            iq_word_q       <= '0;
            noise_idx_q     <= '0;
            noise_word_q    <= '0;
            iq_wr_en_q      <= 1'b0;
            iq_wr_data_q    <= '0;
            noise_wr_en_q   <= 1'b0;
            noise_wr_data_q <= '0;
            overflow_q      <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            re_num_q        <= re_num_d;
            re_cnt_q        <= re_cnt_d;
            iq_half_q       <= iq_half_d;
            iq_word_q       <= iq_word_d;
            noise_idx_q     <= noise_idx_d;
            noise_word_q    <= noise_word_d;
            iq_wr_en_q      <= iq_wr_en_d;
            iq_wr_data_q    <= iq_wr_data_d;
            noise_wr_en_q   <= noise_wr_en_d;
            noise_wr_data_q <= noise_wr_data_d;
            overflow_q      <= overflow_d;
            done_q          <= done_d;
        end
    end

    assign o_iq_fifo_wr_en      = iq_wr_en_q;
    assign o_iq_fifo_wr_data    = iq_wr_data_q;
    assign o_noise_fifo_wr_en   = noise_wr_en_q;
    assign o_noise_fifo_wr_data = noise_wr_data_q;
    assign o_busy               = (state_q == ST_PACK) || (state_q == ST_FLUSH);
    assign o_user_done          = done_q;
    assign o_overflow           = overflow_q;

endmodule

// File: tb/tb_updslow_llr_fifo_packer.sv
// Bench for updslow_llr_fifo_packer: directed user scenarios plus randomized traffic,
// every output checked each cycle against a queue-based reference model.
module tb_updslow_llr_fifo_packer;
  logic         i_core_clk = 1'b0;
  logic         i_rx_rstn = 1'b0;
  logic         i_rx_fsm_rstn = 1'b1;
  logic         i_user_start = 1'b0;
  logic [15:0]  i_user_re_num = '0;
  logic         i_data_strobe = 1'b0;
  logic [15:0]  i_re0_data_i = '0, i_re0_data_q = '0, i_re1_data_i = '0, i_re1_data_q = '0;
  logic         i_noise_strobe = 1'b0;
  logic [15:0]  i_noise_data = '0;
  logic         i_iq_fifo_full = 1'b0;
  logic         i_noise_fifo_full = 1'b0;
  logic         o_iq_fifo_wr_en, o_noise_fifo_wr_en, o_busy, o_user_done, o_overflow;
  logic [127:0] o_iq_fifo_wr_data, o_noise_fifo_wr_data;
  logic         rst_all_n;

  int n_checks = 0;
  int n_errors = 0;

  updslow_llr_fifo_packer dut (
    .i_core_clk(i_core_clk), .i_rx_rstn(i_rx_rstn), .i_rx_fsm_rstn(i_rx_fsm_rstn),
    .i_user_start(i_user_start), .i_user_re_num(i_user_re_num),
    .i_data_strobe(i_data_strobe), .i_re0_data_i(i_re0_data_i), .i_re0_data_q(i_re0_data_q),
    .i_re1_data_i(i_re1_data_i), .i_re1_data_q(i_re1_data_q),
    .i_noise_strobe(i_noise_strobe), .i_noise_data(i_noise_data),
    .i_iq_fifo_full(i_iq_fifo_full), .i_noise_fifo_full(i_noise_fifo_full),
    .o_iq_fifo_wr_en(o_iq_fifo_wr_en), .o_iq_fifo_wr_data(o_iq_fifo_wr_data),
    .o_noise_fifo_wr_en(o_noise_fifo_wr_en), .o_noise_fifo_wr_data(o_noise_fifo_wr_data),
    .o_busy(o_busy), .o_user_done(o_user_done), .o_overflow(o_overflow)
  );

  // clock / reset
  always #5 i_core_clk = ~i_core_clk;
  assign rst_all_n = i_rx_rstn & i_rx_fsm_rstn;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: user progress as a count, packing as queues of accepted items
  localparam int M_IDLE = 0, M_PACK = 1, M_FLUSH = 2, M_DONE = 3;
  int           m_st = M_IDLE;
  int unsigned  m_eff = 0, m_cnt = 0;
  logic [63:0]  m_beats[$];
  logic [15:0]  m_noise[$];
  logic         m_iq_en = 0, m_noise_en = 0, m_ovf = 0, m_done = 0, m_busy = 0;
  logic [127:0] m_iq_data = '0, m_noise_data = '0;

  task automatic emit_iq();
    logic [127:0] w = '0;
    for (int k = 0; k < m_beats.size(); k++) w[64*k +: 64] = m_beats[k];
    m_beats.delete();
    if (i_iq_fifo_full) m_ovf = 1'b1;
    else begin m_iq_en = 1'b1; m_iq_data = w; end
  endtask

  task automatic emit_noise();
    logic [127:0] w = '0;
    for (int k = 0; k < m_noise.size(); k++) w[16*k +: 16] = m_noise[k];
    m_noise.delete();
    if (i_noise_fifo_full) m_ovf = 1'b1;
    else begin m_noise_en = 1'b1; m_noise_data = w; end
  endtask

  task automatic model_step();
    m_iq_en = 1'b0;
    m_noise_en = 1'b0;
    if (i_user_start) begin
      m_eff = ((32'(i_user_re_num) + 1) / 2) * 2;
      if (m_eff > 65534) m_eff = 65534;
      m_cnt = 0;
      m_beats.delete();
      m_noise.delete();
      m_ovf = 1'b0;
      m_st = (m_eff == 0) ? M_DONE : M_PACK;
    end else if (m_st == M_PACK) begin
      if (i_noise_strobe) begin
        m_noise.push_back(i_noise_data);
        if (m_noise.size() == 8) emit_noise();
      end
      if (i_data_strobe) begin
        m_beats.push_back({i_re1_data_q, i_re1_data_i, i_re0_data_q, i_re0_data_i});
        m_cnt += 2;
        if (m_beats.size() == 2) emit_iq();
        if (m_cnt >= m_eff) m_st = M_FLUSH;
      end
    end else if (m_st == M_FLUSH) begin
      if (m_beats.size() != 0) emit_iq();
      if (m_noise.size() != 0) emit_noise();
      m_st = M_DONE;
    end else begin
      m_st = M_IDLE;
    end
    m_done = (m_st == M_DONE);
    m_busy = (m_st == M_PACK) || (m_st == M_FLUSH);
  endtask

  initial begin
    forever begin
      @(posedge i_core_clk or negedge rst_all_n);
      if (!rst_all_n) begin
        m_st = M_IDLE; m_eff = 0; m_cnt = 0;
        m_beats.delete(); m_noise.delete();
        m_iq_en = 0; m_noise_en = 0; m_ovf = 0; m_done = 0; m_busy = 0;
        m_iq_data = '0; m_noise_data = '0;
      end else begin
        model_step();
      end
    end
  end

  // scoreboard: per-cycle comparison plus write/done tallies for the directed cases
  int           iq_wr_cnt = 0, noise_wr_cnt = 0, done_cnt = 0;
  logic [127:0] last_iq = '0, first_noise = '0, last_noise = '0;

  always @(negedge i_core_clk) begin
    check_val("busy", o_busy, m_busy);
    check_val("user_done", o_user_done, m_done);
    check_val("overflow", o_overflow, m_ovf);
    check_val("iq_wr_en", o_iq_fifo_wr_en, m_iq_en);
    check_val("noise_wr_en", o_noise_fifo_wr_en, m_noise_en);
    if (o_iq_fifo_wr_en && m_iq_en) check_val("iq_wr_data", o_iq_fifo_wr_data, m_iq_data);
    if (o_noise_fifo_wr_en && m_noise_en) check_val("noise_wr_data", o_noise_fifo_wr_data, m_noise_data);
    if (o_iq_fifo_wr_en) begin iq_wr_cnt++; last_iq = o_iq_fifo_wr_data; end
    if (o_noise_fifo_wr_en) begin
      if (noise_wr_cnt == 0) first_noise = o_noise_fifo_wr_data;
      noise_wr_cnt++;
      last_noise = o_noise_fifo_wr_data;
    end
    if (o_user_done) done_cnt++;
  end

  // driver tasks
  task automatic cyc(input logic st, input logic [15:0] rn, input logic ds, input logic [63:0] beat,
                     input logic ns, input logic [15:0] nd, input logic iqf, input logic nf);
    @(negedge i_core_clk);
    i_user_start = st;
    i_user_re_num = rn;
    i_data_strobe = ds;
    {i_re1_data_q, i_re1_data_i, i_re0_data_q, i_re0_data_i} = beat;
    i_noise_strobe = ns;
    i_noise_data = nd;
    i_iq_fifo_full = iqf;
    i_noise_fifo_full = nf;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 16'd0, 0, 64'd0, 0, 16'd0, 0, 0);
  endtask

  task automatic start_user(input logic [15:0] rn);
    cyc(1, rn, 0, 64'd0, 0, 16'd0, 0, 0);
  endtask

  task automatic beat(input logic [63:0] b);
    cyc(0, 16'd0, 1, b, 0, 16'd0, 0, 0);
  endtask

  task automatic clear_counts();
    @(posedge i_core_clk);
    #1;
    iq_wr_cnt = 0; noise_wr_cnt = 0; done_cnt = 0;
    last_iq = '0; first_noise = '0; last_noise = '0;
  endtask

  initial begin
    logic [63:0] b1, b2;
    #3;
    check_val("rst_iq_wr_en", o_iq_fifo_wr_en, 1'b0);
    check_val("rst_iq_wr_data", o_iq_fifo_wr_data, 128'd0);
    check_val("rst_noise_wr_en", o_noise_fifo_wr_en, 1'b0);
    check_val("rst_busy", o_busy, 1'b0);
    check_val("rst_done", o_user_done, 1'b0);
    check_val("rst_overflow", o_overflow, 1'b0);
    repeat (3) @(negedge i_core_clk);
    i_rx_rstn = 1'b1;
    idle(2);

    // two beats make one word
    clear_counts();
    start_user(16'd4);
    beat({16'd4, 16'd3, 16'd2, 16'd1});
    beat({16'd8, 16'd7, 16'd6, 16'd5});
    idle(5);
    check_val("t1_iq_writes", iq_wr_cnt, 1);
    check_val("t1_iq_word", last_iq, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check_val("t1_done_cnt", done_cnt, 1);

    // odd beat count flushes a half word
    clear_counts();
    start_user(16'd6);
    beat(64'h1111_2222_3333_4444);
    beat(64'h5555_6666_7777_8888);
    beat(64'h9999_aaaa_bbbb_cccc);
    idle(5);
    check_val("t2_iq_writes", iq_wr_cnt, 2);
    check_val("t2_flush_word", last_iq, {64'd0, 64'h9999_aaaa_bbbb_cccc});

    // eleven noise samples, last data beats in the same cycles
    clear_counts();
    start_user(16'd8);
    for (int i = 0; i < 11; i++)
      cyc(0, 16'd0, (i >= 7), {4{16'(i)}}, 1, 16'h10 + 16'(i), 0, 0);
    idle(5);
    check_val("t3_noise_writes", noise_wr_cnt, 2);
    check_val("t3_noise_full", first_noise, 128'h0017_0016_0015_0014_0013_0012_0011_0010);
    check_val("t3_noise_flush", last_noise, 128'h001a_0019_0018);
    check_val("t3_iq_writes", iq_wr_cnt, 2);

    // FIFO full on the completing beat
    clear_counts();
    start_user(16'd4);
    beat(64'h0123_4567_89ab_cdef);
    cyc(0, 16'd0, 1, 64'hfedc_ba98_7654_3210, 0, 16'd0, 1, 0);
    idle(4);
    check_val("t4_iq_writes", iq_wr_cnt, 0);
    check_val("t4_ovf_sticky", o_overflow, 1'b1);
    start_user(16'd2);
    idle(1);
    check_val("t4_ovf_cleared", o_overflow, 1'b0);
    beat(64'h1);
    idle(4);

    // restart mid-PACK with a half word pending; the coincident strobe is dropped
    clear_counts();
    start_user(16'd8);
    beat(64'haaaa_aaaa_aaaa_aaaa);
    cyc(1, 16'd4, 1, 64'hdead_dead_dead_dead, 0, 16'd0, 0, 0);
    beat(64'h0000_0000_0000_0b0b);
    beat(64'h0000_0000_0000_0c0c);
    idle(5);
    check_val("t5_iq_writes", iq_wr_cnt, 1);
    check_val("t5_iq_word", last_iq, {64'h0000_0000_0000_0c0c, 64'h0000_0000_0000_0b0b});
    check_val("t5_done_cnt", done_cnt, 1);

    // zero-RE user
    clear_counts();
    start_user(16'd0);
    idle(4);
    check_val("t6_done_cnt", done_cnt, 1);
    check_val("t6_writes", iq_wr_cnt + noise_wr_cnt, 0);

    // FSM reset while a write is on the port
    start_user(16'd8);
    beat(64'h1);
    beat(64'h2);
    @(posedge i_core_clk);
    #1;
    check_val("fsmrst_pre_wren", o_iq_fifo_wr_en, 1'b1);
    #1;
    i_rx_fsm_rstn = 1'b0;
    #1;
    check_val("fsmrst_wren", o_iq_fifo_wr_en, 1'b0);
    check_val("fsmrst_wrdata", o_iq_fifo_wr_data, 128'd0);
    check_val("fsmrst_busy", o_busy, 1'b0);
    @(negedge i_core_clk);
    i_data_strobe = 1'b0;
    i_rx_fsm_rstn = 1'b1;
    idle(2);

    // largest RE count saturates at 0xFFFE
    clear_counts();
    start_user(16'hffff);
    for (int i = 0; i < 32767; i++)
      cyc(0, 16'd0, 1, {$urandom, $urandom}, $urandom_range(0, 1), 16'($urandom), 0, 0);
    idle(5);
    check_val("sat_iq_writes", iq_wr_cnt, 16384);
    check_val("sat_done_cnt", done_cnt, 1);

    // randomized users
    for (int u = 0; u < 40; u++) begin
      start_user(16'($urandom_range(0, 24)));
      for (int c = 0; c < 24; c++)
        cyc(($urandom_range(0, 39) == 0), 16'($urandom_range(0, 24)),
            ($urandom_range(0, 9) < 7), {$urandom, $urandom},
            $urandom_range(0, 1), 16'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      idle(3);
    end

    idle(3);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
